reg_file_param: RTL

// - Parametrised 2-read/1-write register file; next generation of the fixed 8x10 tri-state file.
// - Adds configurable width and depth, an independent read enable on both ports, and registered

---
 rtl/reg_file_param.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised 2-read/1-write register file with registered,
// independently enabled read ports, write-to-read bypass, per-entry written
// flags, optional hardwired-zero R0 and per-port address/uninitialised errors.
module reg_file_param #(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 8,
  parameter bit ZERO_R0 = 1'b0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic [WIDTH-1:0] D,
  input  logic             ENW,
  input  logic [AW-1:0]    WRA,
  input  logic             ENR0,
  input  logic [AW-1:0]    RDA0,
  input  logic             ENR1,
  input  logic [AW-1:0]    RDA1,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             ERR0,
  output logic             ERR1
);

  logic [WIDTH-1:0] r_regs    [DEPTH];
  logic             r_written [DEPTH];

  logic             w_wrInRange;
  logic             w_wrAccept;
  logic [WIDTH-1:0] w_rdData0;
  logic             w_rdErr0;
  logic [WIDTH-1:0] w_rdData1;
  logic             w_rdErr1;

  // A write only lands when it targets an existing, non-hardwired register.
  assign w_wrInRange = (32'(WRA) < DEPTH);
  assign w_wrAccept  = ENW && w_wrInRange && !(ZERO_R0 && (WRA == '0));

  // Storage and written flags; R0 counts as written when it is hardwired.
  always_ff @(posedge CLKb) begin
    if (!RSTb) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i]    <= '0;
        r_written[i] <= (ZERO_R0 && (i == 0));
      end
    end else if (w_wrAccept) begin
      r_regs[WRA]    <= D;
      r_written[WRA] <= 1'b1;
    end
  end

  // Next read-port-0 value: range error, hardwired zero, bypass, then storage.
  always_comb begin
    w_rdData0 = '0;
    w_rdErr0  = 1'b0;
    if (32'(RDA0) >= DEPTH) begin
      w_rdData0 = '0;
      w_rdErr0  = 1'b1;
    end else if (ZERO_R0 && (RDA0 == '0)) begin
      w_rdData0 = '0;
      w_rdErr0  = 1'b0;
    end else if (w_wrAccept && (WRA == RDA0)) begin
      w_rdData0 = D;
      w_rdErr0  = 1'b0;
    end else begin
      w_rdData0 = r_regs[RDA0];
      w_rdErr0  = ~r_written[RDA0];
    end
  end

  // Next read-port-1 value, same priority as port 0.
  always_comb begin
    w_rdData1 = '0;
    w_rdErr1  = 1'b0;
    if (32'(RDA1) >= DEPTH) begin
      w_rdData1 = '0;
      w_rdErr1  = 1'b1;
    end else if (ZERO_R0 && (RDA1 == '0)) begin
      w_rdData1 = '0;
      w_rdErr1  = 1'b0;
    end else if (w_wrAccept && (WRA == RDA1)) begin
      w_rdData1 = D;
      w_rdErr1  = 1'b0;
    end else begin
      w_rdData1 = r_regs[RDA1];
      w_rdErr1  = ~r_written[RDA1];
    end
  end

  // Port 0 output register; holds while its enable is low.
  always_ff @(posedge CLKb) begin
    if (!RSTb) begin
      Q0   <= '0;
      ERR0 <= 1'b0;
    end else if (ENR0) begin
      Q0   <= w_rdData0;
      ERR0 <= w_rdErr0;
    end
  end

  // Port 1 output register; holds while its enable is low.
  always_ff @(posedge CLKb) begin
    if (!RSTb) begin
      Q1   <= '0;
      ERR1 <= 1'b0;
    end else if (ENR1) begin
      Q1   <= w_rdData1;
      ERR1 <= w_rdErr1;
    end
  end

endmodule
